// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store access unit: funct3 codes,
// FSM state encoding and access-size decoding.
package mau_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      B0   = 2'd1,
      B1   = 2'd2,
      RESP = 2'd3
   } mau_state_t;

   // Byte-lane mask for an access size taken from funct3[1:0].
   function automatic logic [3:0] width_mask(input logic [1:0] size);
      case (size)
         2'b00:   width_mask = 4'b0001;
         2'b01:   width_mask = 4'b0011;
         default: width_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [2:0] width_bytes(input logic [1:0] size);
      case (size)
         2'b00:   width_bytes = 3'd1;
         2'b01:   width_bytes = 3'd2;
         default: width_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
      if (we) is_illegal = funct3[2];
      else    is_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

endpackage

// File: rtl/mau_align.sv
// Load-side alignment: shifts the one- or two-word raw data down by the byte
// offset and applies sign or zero extension for the load width.
module mau_align
   import mau_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [63:0] raw64,
   output logic [31:0] rdata
);

   logic [31:0] raw;

   assign raw = raw64[{off, 3'b000} +: 32];

   always_comb begin
      rdata = raw;
      case (funct3)
         F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
         F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   rdata = {24'b0, raw[7:0]};
         F3_HU:   rdata = {16'b0, raw[15:0]};
         default: rdata = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one core request becomes one or two word-aligned memory
// beats with byte strobes; load data is realigned and extended on response.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [3:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rd_data
);

   mau_state_t        state;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              illegal_q;
   logic              cross_q;
   logic [DATA_W-1:0] lo_buf;

   logic [7:0]          mask8;
   logic [2*DATA_W-1:0] wdata64;
   logic [ADDR_W-1:0]   addr_lo;
   logic [ADDR_W-1:0]   addr_hi;
   logic [2*DATA_W-1:0] raw64;
   logic [DATA_W-1:0]   aligned;

   // Handshake: a request transfers on a cycle where req_valid and req_ready
   // are both high; req_ready is high only in IDLE, responses are never stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         illegal_q <= 1'b0;
         cross_q   <= 1'b0;
         lo_buf    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  illegal_q <= is_illegal(req_we, req_funct3);
                  cross_q   <= ({1'b0, req_addr[1:0]} + width_bytes(req_funct3[1:0])) > 3'd4;
                  state     <= B0;
               end
            end
            B0: state <= (!illegal_q && cross_q) ? B1 : RESP;
            B1: begin
               if (!we_q) lo_buf <= mem_rd_data;
               state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mask8   = {4'b0, width_mask(f3_q[1:0])} << addr_q[1:0];
   assign wdata64 = {{DATA_W{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
   assign addr_lo = {addr_q[ADDR_W-1:2], 2'b00};
   assign addr_hi = addr_lo + ADDR_W'(4);
   assign raw64   = cross_q ? {mem_rd_data, lo_buf} : {{DATA_W{1'b0}}, mem_rd_data};

   mau_align u_align (
      .off    (addr_q[1:0]),
      .funct3 (f3_q),
      .raw64  (raw64),
      .rdata  (aligned)
   );

   // Every output is forced low while reset is high, so a store caught
   // between its two beats never issues the second write.
   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_err     = 1'b0;
      rsp_rdata   = '0;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      mem_wstrb   = 4'b0;
      if (!reset) begin
         case (state)
            IDLE: req_ready = 1'b1;
            B0: begin
               if (!illegal_q) begin
                  mem_addr  = addr_lo;
                  mem_rd_en = !we_q;
                  mem_wr_en = we_q;
                  if (we_q) begin
                     mem_wstrb   = mask8[3:0];
                     mem_wr_data = wdata64[DATA_W-1:0];
                  end
               end
            end
            B1: begin
               mem_addr  = addr_hi;
               mem_rd_en = !we_q;
               mem_wr_en = we_q;
               if (we_q) begin
                  mem_wstrb   = mask8[7:4];
                  mem_wr_data = wdata64[2*DATA_W-1:DATA_W];
               end
            end
            default: begin
               rsp_valid = 1'b1;
               rsp_err   = illegal_q;
               if (!we_q && !illegal_q) rsp_rdata = aligned;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-laned word memory model;
// expected values are hand-computed from the request and memory contents.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rd_data;

   logic [31:0] mem [0:255];
   logic        poke_en;
   logic [7:0]  poke_idx;
   logic [31:0] poke_data;
   int          wr_count;
   int          checks;
   int          errors;

   mem_access_unit dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .mem_wstrb   (mem_wstrb),
      .mem_rd_data (mem_rd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Word memory indexed by address bits [9:2]; 0xFFFFFFFC lands on word 255.
   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_addr[9:2]];
      if (mem_wr_en) begin
         wr_count <= wr_count + 1;
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_idx  = a[9:2];
      poke_data = d;
      @(negedge clk);
      poke_en   = 1'b0;
   endtask

   // Presents a request in an idle cycle and returns at the negedge of the B0 cycle.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      @(negedge clk);
      chk("req_ready_before_issue", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic chk_rd_beat(input string tag, input logic [31:0] a);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
      chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
   endtask

   task automatic chk_wr_beat(input string tag, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d);
      chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd1);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(s));
      chk({tag, "_wdata"}, mem_wr_data, d);
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] d, input logic e);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_rdata"}, rsp_rdata, d);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e));
      chk({tag, "_no_mem_in_resp"}, 32'({mem_rd_en, mem_wr_en}), 32'd0);
   endtask

   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] exp);
      issue(1'b0, f3, a, 32'h0);
      chk_rd_beat({tag, "_b0"}, {a[31:2], 2'b00});
      @(negedge clk);
      chk_rsp(tag, exp, 1'b0);
   endtask

   int wr_before;

   initial begin
      checks     = 0;
      errors     = 0;
      wr_count   = 0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      poke_en    = 1'b0;
      poke_idx   = 8'h0;
      poke_data  = 32'h0;

      poke(32'h0000_0100, 32'hDEAD_BEEF);
      poke(32'h0000_0104, 32'h8877_6655);
      poke(32'h0000_0108, 32'h0000_0000);
      poke(32'hFFFF_FFFC, 32'h1122_3344);
      poke(32'h0000_0000, 32'h0000_00F0);

      @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_mem_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      load("lw_aligned", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("lw_idle_ready", 32'(req_ready), 32'd1);
      chk("lw_rsp_pulse", 32'(rsp_valid), 32'd0);

      load("lb_sign", 3'b000, 32'h0000_0103, 32'hFFFF_FFDE);
      load("lbu_zero", 3'b100, 32'h0000_0103, 32'h0000_00DE);
      load("lh_sign", 3'b001, 32'h0000_0102, 32'hFFFF_DEAD);
      load("lhu_zero", 3'b101, 32'h0000_0100, 32'h0000_BEEF);

      poke(32'h0000_0100, 32'h4433_2211);
      issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
      chk_rd_beat("lw_cross_b0", 32'h0000_0100);
      chk("lw_cross_b0_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk_rd_beat("lw_cross_b1", 32'h0000_0104);
      chk("lw_cross_b1_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk_rsp("lw_cross", 32'h6655_4433, 1'b0);

      issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
      chk_rd_beat("lh_wrap_b0", 32'hFFFF_FFFC);
      @(negedge clk);
      chk_rd_beat("lh_wrap_b1", 32'h0000_0000);
      @(negedge clk);
      chk_rsp("lh_wrap", 32'hFFFF_F011, 1'b0);

      issue(1'b1, 3'b001, 32'h0000_0107, 32'h0000_ABCD);
      chk_wr_beat("sh_cross_b0", 32'h0000_0104, 4'b1000, 32'hCD00_0000);
      @(negedge clk);
      chk_wr_beat("sh_cross_b1", 32'h0000_0108, 4'b0001, 32'h0000_00AB);
      @(negedge clk);
      chk_rsp("sh_cross", 32'h0, 1'b0);
      chk("sh_cross_mem_lo", mem[8'h41], 32'hCD77_6655);
      chk("sh_cross_mem_hi", mem[8'h42], 32'h0000_00AB);

      issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A);
      chk_wr_beat("sb_b0", 32'h0000_0100, 4'b0010, 32'h0000_5A00);
      @(negedge clk);
      chk_rsp("sb", 32'h0, 1'b0);
      chk("sb_mem", mem[8'h40], 32'h4433_5A11);

      issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
      chk("illegal_ld_b0_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
      @(negedge clk);
      chk_rsp("illegal_ld", 32'h0, 1'b1);

      wr_before = wr_count;
      issue(1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF);
      chk("illegal_st_b0_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
      @(negedge clk);
      chk_rsp("illegal_st", 32'h0, 1'b1);
      chk("illegal_st_no_write", 32'(wr_count - wr_before), 32'd0);

      wr_before = wr_count;
      issue(1'b1, 3'b010, 32'h0000_0106, 32'h1122_3344);
      chk_wr_beat("sw_rst_b0", 32'h0000_0104, 4'b1100, 32'h3344_0000);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("sw_rst_b1_wr_en", 32'(mem_wr_en), 32'd0);
      chk("sw_rst_b1_wstrb", 32'(mem_wstrb), 32'd0);
      chk("sw_rst_b1_wdata", mem_wr_data, 32'h0);
      chk("sw_rst_ready_in_reset", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("sw_rst_no_rsp_in_reset", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      #1;
      chk("sw_rst_ready_after", 32'(req_ready), 32'd1);
      chk("sw_rst_no_rsp_after", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("sw_rst_no_rsp_later", 32'(rsp_valid), 32'd0);
      chk("sw_rst_one_write", 32'(wr_count - wr_before), 32'd1);
      chk("sw_rst_mem_lo", mem[8'h41], 32'h3344_6655);
      chk("sw_rst_mem_hi", mem[8'h42], 32'h0000_00AB);

      load("lw_after_reset", 3'b010, 32'h0000_0104, 32'h3344_6655);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "bench did not finish in time");
   end

endmodule
